op_decoder_seq: RTL and testbench

- Parametrised, registered one-hot operation decoder for ALU operation selection; generalises the 3-to-8 select decode to SEL_W bits.
- Adds a valid/ready accept handshake and per-opcode multi-cycle hold: each op's one-hot line stays asserted for 1 or MULTI_CYCLES cycles.
- Adds a done pulse and a flush.
- Sits between the instruction/control front end and the ALU datapath enables.

---
 rtl/op_decoder_if.sv | 35 +++
 rtl/op_decoder_seq.sv | 94 +++++++++
 tb/tb_op_decoder_seq.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/op_decoder_if.sv
// ============================================================================
// Module   : op_decoder_if
// Brief    : Handshake/control bundle between front end and op_decoder_seq.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface op_decoder_if #(
    parameter int SEL_W = 3
);
    localparam int OUT_W = 1 << SEL_W;

    logic             enable;
    logic [SEL_W-1:0] select;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [OUT_W-1:0] op_onehot;
    logic [SEL_W-1:0] op_code;
    logic             op_active;
    logic             op_last;
    logic             done;

    modport master (
        output enable, select, in_valid, flush,
        input  in_ready, op_onehot, op_code, op_active, op_last, done
    );

    modport slave (
        input  enable, select, in_valid, flush,
        output in_ready, op_onehot, op_code, op_active, op_last, done
    );
endinterface

`default_nettype wire

// File: rtl/op_decoder_seq.sv
// ============================================================================
// Module   : op_decoder_seq
// Brief    : Registered one-hot op decoder with accept handshake, per-opcode
//            multi-cycle hold, done pulse and flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module op_decoder_seq #(
    parameter int                      SEL_W        = 3,
    parameter logic [(2**SEL_W)-1:0]   MULTI_MASK   = 8'b1100_0000,
    parameter int                      MULTI_CYCLES = 4
) (
    input  wire            clk,
    input  wire            rst,
    op_decoder_if.slave    bus
);
    localparam int OUT_W = 2 ** SEL_W;
    localparam int CNT_W = $clog2(MULTI_CYCLES);

    localparam logic [0:0]       S_IDLE   = 1'b0;
    localparam logic [0:0]       S_EXEC   = 1'b1;
    localparam logic [CNT_W-1:0] c_CNT_MC = CNT_W'(MULTI_CYCLES - 1);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [OUT_W-1:0] r_onehot;
    logic [SEL_W-1:0] r_code;

    logic [0:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [OUT_W-1:0] w_onehot_nxt;
    logic [SEL_W-1:0] w_code_nxt;
    logic             w_ready;
    logic             w_accept;
    logic             w_last;

    // Ready while idle or on the final cycle of an op, so ops chain with no bubble.
    assign w_ready  = ~rst & bus.enable & ~bus.flush &
                      ((r_state == S_IDLE) | (r_cnt == '0));
    assign w_accept = bus.in_valid & w_ready;
    assign w_last   = (r_state == S_EXEC) & (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_onehot <= '0;
            r_code   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_onehot <= w_onehot_nxt;
            r_code   <= w_code_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_onehot_nxt = r_onehot;
        w_code_nxt   = r_code;
        if (bus.flush) begin
            w_state_nxt  = S_IDLE;
            w_cnt_nxt    = '0;
            w_onehot_nxt = '0;
            w_code_nxt   = '0;
        end else if (w_accept) begin
            w_state_nxt  = S_EXEC;
            w_onehot_nxt = OUT_W'(1) << bus.select;
            w_code_nxt   = bus.select;
            w_cnt_nxt    = MULTI_MASK[bus.select] ? c_CNT_MC : '0;
        end else if (r_state == S_EXEC) begin
            if (r_cnt != '0) begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
            end else begin
                w_state_nxt  = S_IDLE;
                w_onehot_nxt = '0;
                w_code_nxt   = '0;
            end
        end
    end

    always_comb begin
        bus.in_ready  = w_ready;
        bus.op_onehot = r_onehot;
        bus.op_code   = r_code;
        bus.op_active = |r_onehot;
        bus.op_last   = w_last;
        bus.done      = w_last & ~bus.flush;
    end
endmodule

`default_nettype wire

// File: tb/tb_op_decoder_seq.sv
// ============================================================================
// Module   : tb_op_decoder_seq
// Brief    : Directed self-checking bench for op_decoder_seq (SEL_W=3 and 4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_op_decoder_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    op_decoder_if #(.SEL_W(3)) a_if ();
    op_decoder_if #(.SEL_W(4)) b_if ();

    op_decoder_seq #(
        .SEL_W(3), .MULTI_MASK(8'b1100_0000), .MULTI_CYCLES(4)
    ) u_dut_a (
        .clk(clk), .rst(rst), .bus(a_if.slave)
    );

    op_decoder_seq #(
        .SEL_W(4), .MULTI_MASK(16'h8000), .MULTI_CYCLES(4)
    ) u_dut_b (
        .clk(clk), .rst(rst), .bus(b_if.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge; inputs are then driven and outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [7:0] oh, input logic last,
                         input logic dn, input logic rdy);
        #1;
        chk({tag, ".onehot"}, 32'(a_if.op_onehot), 32'(oh));
        chk({tag, ".active"}, 32'(a_if.op_active), 32'(oh != 8'h00));
        chk({tag, ".last"},   32'(a_if.op_last),   32'(last));
        chk({tag, ".done"},   32'(a_if.done),      32'(dn));
        chk({tag, ".ready"},  32'(a_if.in_ready),  32'(rdy));
    endtask

    initial begin
        a_if.enable = 1'b1; a_if.select = 3'd3; a_if.in_valid = 1'b1; a_if.flush = 1'b0;
        b_if.enable = 1'b0; b_if.select = 4'd0; b_if.in_valid = 1'b0; b_if.flush = 1'b0;

        // Reset held two edges with a pending request
        tick();
        chk_a("rst1", 8'h00, 1'b0, 1'b0, 1'b0);
        chk("rst1.code", 32'(a_if.op_code), 32'd0);
        tick();
        chk_a("rst2", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; a_if.in_valid = 1'b0;
        tick();
        chk_a("idle", 8'h00, 1'b0, 1'b0, 1'b1);

        // Single-cycle op 2
        a_if.select = 3'd2; a_if.in_valid = 1'b1;
        tick(); a_if.in_valid = 1'b0;
        chk_a("single", 8'h04, 1'b1, 1'b1, 1'b1);
        chk("single.code", 32'(a_if.op_code), 32'd2);
        tick();
        chk_a("single.end", 8'h00, 1'b0, 1'b0, 1'b1);

        // Back-to-back 0, 1, 5
        a_if.select = 3'd0; a_if.in_valid = 1'b1;
        tick(); a_if.select = 3'd1;
        chk_a("b2b0", 8'h01, 1'b1, 1'b1, 1'b1);
        tick(); a_if.select = 3'd5;
        chk_a("b2b1", 8'h02, 1'b1, 1'b1, 1'b1);
        tick(); a_if.in_valid = 1'b0;
        chk_a("b2b5", 8'h20, 1'b1, 1'b1, 1'b1);
        chk("b2b5.code", 32'(a_if.op_code), 32'd5);
        tick();
        chk_a("b2b.end", 8'h00, 1'b0, 1'b0, 1'b1);

        // Multi-cycle op 7 with op 1 queued behind it
        a_if.select = 3'd7; a_if.in_valid = 1'b1;
        tick(); a_if.select = 3'd1;
        chk_a("mc.c1", 8'h80, 1'b0, 1'b0, 1'b0);
        tick(); chk_a("mc.c2", 8'h80, 1'b0, 1'b0, 1'b0);
        tick(); chk_a("mc.c3", 8'h80, 1'b0, 1'b0, 1'b0);
        chk("mc.c3.code", 32'(a_if.op_code), 32'd7);
        tick(); chk_a("mc.c4", 8'h80, 1'b1, 1'b1, 1'b1);
        tick(); a_if.in_valid = 1'b0;
        chk_a("mc.next", 8'h02, 1'b1, 1'b1, 1'b1);
        tick(); chk_a("mc.end", 8'h00, 1'b0, 1'b0, 1'b1);

        // Flush in the second active cycle of op 6
        a_if.select = 3'd6; a_if.in_valid = 1'b1;
        tick(); a_if.in_valid = 1'b0;
        chk_a("fl.c1", 8'h40, 1'b0, 1'b0, 1'b0);
        tick(); a_if.flush = 1'b1; a_if.in_valid = 1'b1;
        chk_a("fl.c2", 8'h40, 1'b0, 1'b0, 1'b0);
        tick(); a_if.flush = 1'b0; a_if.in_valid = 1'b0;
        chk_a("fl.after", 8'h00, 1'b0, 1'b0, 1'b1);
        chk("fl.code", 32'(a_if.op_code), 32'd0);
        tick(); chk_a("fl.idle", 8'h00, 1'b0, 1'b0, 1'b1);

        // Flush while idle is harmless
        a_if.flush = 1'b1;
        tick(); a_if.flush = 1'b0;
        chk_a("flidle", 8'h00, 1'b0, 1'b0, 1'b1);

        // enable gating
        a_if.enable = 1'b0; a_if.select = 3'd4; a_if.in_valid = 1'b1;
        #1 chk("en.ready", 32'(a_if.in_ready), 32'd0);
        tick(); chk_a("en.noop", 8'h00, 1'b0, 1'b0, 1'b0);
        a_if.enable = 1'b1; a_if.select = 3'd7;
        tick(); a_if.enable = 1'b0; a_if.in_valid = 1'b0;
        chk_a("en.c1", 8'h80, 1'b0, 1'b0, 1'b0);
        tick(); chk_a("en.c2", 8'h80, 1'b0, 1'b0, 1'b0);
        tick(); chk_a("en.c3", 8'h80, 1'b0, 1'b0, 1'b0);
        tick(); chk_a("en.c4", 8'h80, 1'b1, 1'b1, 1'b0);
        tick(); chk_a("en.end", 8'h00, 1'b0, 1'b0, 1'b0);

        // SEL_W=4 instance: op 15 multi-cycle, op 14 single-cycle
        b_if.enable = 1'b1; b_if.select = 4'd15; b_if.in_valid = 1'b1;
        tick(); b_if.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("w4.op15", 32'(b_if.op_onehot), 32'h8000);
            chk("w4.op15.done", 32'(b_if.done), 32'(i == 3));
            tick();
        end
        #1 chk("w4.op15.end", 32'(b_if.op_onehot), 32'h0000);
        b_if.select = 4'd14; b_if.in_valid = 1'b1;
        tick(); b_if.in_valid = 1'b0;
        #1;
        chk("w4.op14", 32'(b_if.op_onehot), 32'h4000);
        chk("w4.op14.done", 32'(b_if.done), 32'd1);
        chk("w4.op14.code", 32'(b_if.op_code), 32'd14);
        tick();
        #1 chk("w4.op14.end", 32'(b_if.op_onehot), 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
